// File: rtl/mac_accum_uint8.sv
// Windowed accumulator behind the 8x8 multiplier: realigns the operand valid tag
// to the multiplier latency and emits one registered sum per LEN valid products.
module mac_accum_uint8 #(
  parameter int MUL_LATENCY = 3,
  parameter int LEN         = 9,
  parameter int SUM_W       = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [15:0]      prod,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_valid,
  output logic             busy
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic [MUL_LATENCY-1:0] vpipe;
  logic                   prod_valid;
  logic [CNT_W-1:0]       count;
  logic [SUM_W-1:0]       acc;
  logic [SUM_W-1:0]       next_sum;

  // Valid tags travel alongside the multiplier so prod_valid lines up with prod
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= valid_in;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  assign prod_valid = vpipe[MUL_LATENCY-1];

  always_comb begin
    next_sum = SUM_W'(prod);
    if (count != '0) begin
      next_sum = acc + SUM_W'(prod);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      acc       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else if (prod_valid) begin
      if (count == LAST) begin
        out_sum   <= next_sum;
        out_valid <= 1'b1;
        count     <= '0;
        acc       <= '0;
      end else begin
        acc       <= next_sum;
        count     <= count + 1'b1;
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (count != '0);

endmodule

// File: tb/tb_mac_accum_uint8.sv
// Randomized and directed bench for mac_accum_uint8 with a multiplier model upstream
// and an event-queue reference model checked every cycle.
module tb_mac_accum_uint8;

  localparam int ML    = 3;
  localparam int LEN   = 9;
  localparam int SUM_W = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [7:0]       opA, opB;
  logic [15:0]      prod;
  logic [SUM_W-1:0] out_sum;
  logic             out_valid;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    int          t;
    logic [15:0] p;
  } ev_t;

  ev_t              pend[$];
  int               mCnt  = 0;
  logic [SUM_W-1:0] mSum  = '0;
  logic [SUM_W-1:0] mOut  = '0;
  logic             mPulse = 1'b0;

  int               pulseCyc[$];
  logic [SUM_W-1:0] pulseSum[$];

  mac_accum_uint8 #(.MUL_LATENCY(ML), .LEN(LEN), .SUM_W(SUM_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .prod     (prod),
    .out_sum  (out_sum),
    .out_valid(out_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Free-running upstream multiplier with a fixed ML-cycle latency
  logic [15:0] mulPipe [ML];
  always @(posedge clk) begin
    mulPipe[0] <= 16'(opA) * 16'(opB);
    for (int i = 1; i < ML; i++) mulPipe[i] <= mulPipe[i-1];
  end
  assign prod = mulPipe[ML-1];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each issued operand pair becomes a product due for consumption ML edges later
  always @(posedge clk) begin
    ev_t e;
    cyc++;
    if (reset) begin
      pend.delete();
      mCnt   = 0;
      mSum   = '0;
      mOut   = '0;
      mPulse = 1'b0;
    end else begin
      if (valid_in) begin
        e.t = cyc + ML;
        e.p = 16'(opA) * 16'(opB);
        pend.push_back(e);
      end
      mPulse = 1'b0;
      if (pend.size() > 0 && pend[0].t == cyc) begin
        e = pend.pop_front();
        mSum = mSum + SUM_W'(e.p);
        mCnt++;
        if (mCnt == LEN) begin
          mOut   = mSum;
          mSum   = '0;
          mCnt   = 0;
          mPulse = 1'b1;
        end
      end
    end
    #1;
    checkOutput("out_valid", out_valid, mPulse);
    checkOutput("busy", busy, (mCnt != 0));
    checkOutput("out_sum", out_sum, mOut);
    if (out_valid === 1'b1) begin
      pulseCyc.push_back(cyc);
      pulseSum.push_back(out_sum);
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    valid_in = v;
    if (v) begin
      opA = a;
      opB = b;
    end else begin
      opA = 8'($urandom);
      opB = 8'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'd0, 8'd0);
  endtask

  function automatic longint pulseSumAt(input int i);
    if (i < pulseSum.size()) return longint'(pulseSum[i]);
    return -1;
  endfunction

  function automatic longint pulseCycAt(input int i);
    if (i < pulseCyc.size()) return longint'(pulseCyc[i]);
    return -1;
  endfunction

  initial begin
    int t0;
    reset    = 1'b1;
    valid_in = 1'b0;
    opA      = 8'd0;
    opB      = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_out_sum", out_sum, 0);
    checkOutput("reset_busy", busy, 0);

    // Ramp
    pulseCyc.delete(); pulseSum.delete();
    t0 = 0;
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, 8'(k), 8'd1);
      if (k == 1) t0 = cyc;
    end
    idle(6);
    checkOutput("ramp_pulses", pulseCyc.size(), 1);
    checkOutput("ramp_sum", pulseSumAt(0), 45);
    checkOutput("ramp_latency", pulseCycAt(0), t0 + 12);

    // Max value
    pulseCyc.delete(); pulseSum.delete();
    repeat (9) applyStimulus(1'b1, 8'd255, 8'd255);
    idle(6);
    checkOutput("max_pulses", pulseCyc.size(), 1);
    checkOutput("max_sum", pulseSumAt(0), 585225);

    // Bubbles between every product
    pulseCyc.delete(); pulseSum.delete();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 8'd2, 8'd1);
      applyStimulus(1'b0, 8'd0, 8'd0);
    end
    idle(6);
    checkOutput("bubble_pulses", pulseCyc.size(), 1);
    checkOutput("bubble_sum", pulseSumAt(0), 18);

    // Back-to-back windows
    pulseCyc.delete(); pulseSum.delete();
    repeat (9) applyStimulus(1'b1, 8'd1, 8'd1);
    repeat (9) applyStimulus(1'b1, 8'd3, 8'd1);
    idle(6);
    checkOutput("b2b_pulses", pulseCyc.size(), 2);
    checkOutput("b2b_sum0", pulseSumAt(0), 9);
    checkOutput("b2b_sum1", pulseSumAt(1), 27);
    checkOutput("b2b_spacing", pulseCycAt(1) - pulseCycAt(0), 9);

    // Reset mid-window with two tags still in flight
    pulseCyc.delete(); pulseSum.delete();
    repeat (7) applyStimulus(1'b1, 8'd1, 8'd1);
    idle(2);
    checkOutput("midrst_busy_before", busy, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (9) applyStimulus(1'b1, 8'd1, 8'd1);
    idle(8);
    checkOutput("midrst_pulses", pulseCyc.size(), 1);
    checkOutput("midrst_sum", pulseSumAt(0), 9);

    // Asynchronous reset mid-cycle with a partial window and a held result
    repeat (4) applyStimulus(1'b1, 8'd5, 8'd7);
    idle(5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_out_sum", out_sum, 0);
    checkOutput("async_out_valid", out_valid, 0);
    checkOutput("async_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    pulseCyc.delete(); pulseSum.delete();
    idle(10);
    checkOutput("async_quiet_pulses", pulseCyc.size(), 0);

    // Random traffic with random bubbles
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 70), 8'($urandom), 8'($urandom));
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
